// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed multiply/divide unit with Hi/Lo result registers
// Shift-add multiply and restoring divide on magnitudes, signs applied once in FIX.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             MultStart,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t             state, state_d;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      counter;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               start_mult;
    logic               start_div;
    logic               flag_zero;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    // During DIV, acc holds {partial remainder, dividend bits shifting out as quotient bits shift in}.
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = shifted - {1'b0, mcand[WIDTH-1:0]};

    assign prod = neg_q ? -acc : acc;
    assign quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        start_mult = 1'b0;
        start_div  = 1'b0;
        flag_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (MultStart) begin
                    start_mult = 1'b1;
                    state_d    = MULT;
                end else if (DivStart) begin
                    if (B != '0) begin
                        start_div = 1'b1;
                        state_d   = DIV;
                    end else begin
                        flag_zero = 1'b1;
                    end
                end
            end
            MULT:    if (counter == LAST) state_d = FIX;
            DIV:     if (counter == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            counter <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done    <= (state == FIX) | flag_zero;
            DivZero <= flag_zero;
            if (start_mult || start_div) begin
                acc     <= start_mult ? '0 : {{WIDTH{1'b0}}, abs_a};
                mcand   <= {{WIDTH{1'b0}}, start_mult ? abs_a : abs_b};
                mplier  <= abs_b;
                counter <= '0;
                is_div  <= start_div;
                neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                neg_r   <= A[WIDTH-1];
            end
            case (state)
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                end
                DIV: begin
                    if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else              acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        Hi <= rem;
                        Lo <= quot;
                    end else begin
                        Hi <= prod[2*WIDTH-1:WIDTH];
                        Lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against a longint arithmetic model
module tb_mult_div_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        MultStart = 1'b0;
    logic        DivStart = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivZero;

    int n_checks = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
        .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired, simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}; longint avoids the -2^31/-1 overflow.
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q  = la / lb;
        r  = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'(int'($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one start and waits for Done; lat = edges from start edge to Done (-1 on timeout).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int busy_n, output logic dz);
        hi = 'x; lo = 'x; dz = 'x; lat = -1; busy_n = 0;
        @(negedge Clock);
        MultStart = !is_div; DivStart = is_div; A = a; B = b;
        @(posedge Clock); #1;
        MultStart = 0; DivStart = 0; A = $urandom; B = $urandom;
        for (int n = 1; n < 200; n++) begin
            @(negedge Clock);
            if (Done) begin
                lat = n - 1; hi = Hi; lo = Lo; dz = DivZero;
                break;
            end
            if (Busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1; repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", Hi); end
        n_checks++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", Lo); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", Done); end
        n_checks++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero got %b exp 0", DivZero); end
        Reset = 0;
    endtask

    task automatic test_mult_directed();
        logic [31:0] hi, lo; int lat, bn; logic dz;
        run_op(0, 32'd7, 32'hFFFF_FFFD, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_7x-3 got %h_%h exp ffffffff_ffffffeb", hi, lo); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency got %0d exp 33", lat); end
        n_checks++; if (bn !== 33) begin n_fail++; $display("FAIL mult_busy_cycles got %0d exp 33", bn); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL mult_divzero got %b exp 0", dz); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL busy_in_done_cycle got %b exp 0", Busy); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b exp 0", Done); end
        run_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== 64'h3FFF_FFFF_0000_0001) begin n_fail++; $display("FAIL mult_max got %h_%h exp 3fffffff_00000001", hi, lo); end
    endtask

    task automatic test_mult_random();
        logic [31:0] a, b, hi, lo; logic [63:0] exp; int lat, bn; logic dz;
        for (int i = 0; i < 25; i++) begin
            a = rand_op(); b = rand_op();
            exp = model_mul(a, b);
            run_op(0, a, b, hi, lo, lat, bn, dz);
            n_checks++; if ({hi, lo} !== exp || lat !== 33) begin
                n_fail++; $display("FAIL mult_rand %h*%h got %h_%h lat %0d exp %h lat 33", a, b, hi, lo, lat, exp);
            end
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] hi, lo; int lat, bn; logic dz;
        run_op(1, 32'hFFFF_FFF9, 32'd2, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2 got hi %h lo %h exp ffffffff fffffffd", hi, lo); end
        n_checks++; if (lat !== 33 || dz !== 1'b0) begin n_fail++; $display("FAIL div_latency got %0d dz %b exp 33 dz 0", lat, dz); end
        run_op(1, 32'd7, 32'hFFFF_FFFE, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_7/-2 got hi %h lo %h exp 00000001 fffffffd", hi, lo); end
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000 || dz !== 1'b0) begin n_fail++; $display("FAIL div_min/-1 got hi %h lo %h dz %b exp 00000000 80000000 dz 0", hi, lo, dz); end
    endtask

    task automatic test_div_random();
        logic [31:0] a, b, hi, lo; logic [63:0] exp; int lat, bn; logic dz;
        for (int i = 0; i < 25; i++) begin
            a = rand_op(); b = rand_op();
            while (b == 0) b = rand_op();
            exp = model_div(a, b);
            run_op(1, a, b, hi, lo, lat, bn, dz);
            n_checks++; if ({hi, lo} !== exp || lat !== 33) begin
                n_fail++; $display("FAIL div_rand %h/%h got %h_%h lat %0d exp %h lat 33", a, b, hi, lo, lat, exp);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] hi, lo; int lat, bn; logic dz;
        run_op(0, 32'h1234_5678, 32'hFEDC_BA98, hi, lo, lat, bn, dz);
        @(negedge Clock);
        DivStart = 1; A = 32'd5; B = 32'd0;
        @(posedge Clock); #1;
        DivStart = 0; A = $urandom; B = $urandom;
        @(negedge Clock);
        n_checks++; if (Done !== 1'b1 || DivZero !== 1'b1) begin n_fail++; $display("FAIL divzero_flag got done %b dz %b exp 1 1", Done, DivZero); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL divzero_busy got %b exp 0", Busy); end
        n_checks++; if ({Hi, Lo} !== model_mul(32'h1234_5678, 32'hFEDC_BA98)) begin n_fail++; $display("FAIL divzero_hilo got %h_%h exp %h", Hi, Lo, model_mul(32'h1234_5678, 32'hFEDC_BA98)); end
        @(negedge Clock);
        n_checks++; if (Done !== 1'b0 || DivZero !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL divzero_pulse got done %b dz %b busy %b exp 0 0 0", Done, DivZero, Busy); end
    endtask

    task automatic test_arbitration();
        int dones = 0, dzs = 0, lat = -1;
        logic [31:0] hi = 'x, lo = 'x;
        @(negedge Clock);
        MultStart = 1; DivStart = 1; A = 32'd6; B = 32'd4;
        @(posedge Clock); #1;
        MultStart = 0; DivStart = 0;
        for (int n = 1; n < 80; n++) begin
            @(negedge Clock);
            DivStart = (n == 10); A = 32'd9; B = 32'd0;
            if (Done) begin
                dones++;
                if (DivZero) dzs++;
                if (lat < 0) begin lat = n - 1; hi = Hi; lo = Lo; end
            end
        end
        DivStart = 0;
        n_checks++; if ({hi, lo} !== 64'd24 || lat !== 33) begin n_fail++; $display("FAIL arb_result got %h_%h lat %0d exp 24 lat 33", hi, lo, lat); end
        n_checks++; if (dones !== 1 || dzs !== 0) begin n_fail++; $display("FAIL arb_done_count got %0d dz %0d exp 1 dz 0", dones, dzs); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] hi, lo; int lat, bn, dones; logic dz;
        run_op(0, 32'd1000, 32'd1000, hi, lo, lat, bn, dz);
        @(negedge Clock);
        MultStart = 1; A = 32'hDEAD_BEEF; B = 32'h0000_1234;
        @(posedge Clock); #1;
        MultStart = 0;
        repeat (14) @(posedge Clock);
        @(negedge Clock); Reset = 1;
        @(posedge Clock);
        @(negedge Clock); Reset = 0;
        n_checks++; if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_midop got hi %h lo %h busy %b done %b exp 0 0 0 0", Hi, Lo, Busy, Done);
        end
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clock);
            if (Done || Busy) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL reset_midop_quiet got %0d active cycles exp 0", dones); end
        run_op(0, 32'hFFFF_FF00, 32'd77, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== model_mul(32'hFFFF_FF00, 32'd77) || lat !== 33) begin
            n_fail++; $display("FAIL reset_midop_fresh got %h_%h lat %0d exp %h lat 33", hi, lo, lat, model_mul(32'hFFFF_FF00, 32'd77));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo; int lat, bn; logic dz;
        run_op(0, 32'd12345, 32'hFFFF_0000, hi, lo, lat, bn, dz);
        n_checks++; if ({hi, lo} !== model_mul(32'd12345, 32'hFFFF_0000)) begin n_fail++; $display("FAIL b2b_first got %h_%h exp %h", hi, lo, model_mul(32'd12345, 32'hFFFF_0000)); end
        // Still in the Done cycle: the next start goes in immediately.
        DivStart = 1; A = 32'hFFFF_FC19; B = 32'd7;
        @(posedge Clock); #1;
        DivStart = 0; A = $urandom; B = $urandom;
        lat = -1;
        for (int n = 1; n < 100; n++) begin
            @(negedge Clock);
            if (Done) begin lat = n - 1; hi = Hi; lo = Lo; break; end
        end
        n_checks++; if ({hi, lo} !== model_div(32'hFFFF_FC19, 32'd7) || lat !== 33) begin
            n_fail++; $display("FAIL b2b_second got %h_%h lat %0d exp %h lat 33", hi, lo, lat, model_div(32'hFFFF_FC19, 32'd7));
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_mult_random();
        test_div_directed();
        test_div_random();
        test_div_zero();
        test_arbitration();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
